// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types and constants for the sequential ALU: opcode
//                encoding, control FSM states and flag bit positions within
//                the 4-bit {neg, zero, carry, overflow} flag vector.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SHL  = 4'b0101,
        OP_SHR  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_MUL  = 4'b1000,
        OP_DIVU = 4'b1001,
        OP_REMU = 4'b1010
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bit positions inside the flags vector
    localparam int NEG   = 3;
    localparam int ZERO  = 2;
    localparam int CARRY = 1;
    localparam int OVF   = 0;

endpackage
`default_nettype wire

// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_if
//  Description : Operation/result handshake bundle of the sequential ALU.
//                Ports carried:
//                  in_valid / in_ready   - operation handshake
//                  a, b (N bits), ctrl   - operands and opcode
//                  out_valid / out_ready - result handshake
//                  result (N bits), flags - {neg, zero, carry, overflow}
//                master = producer of operations, slave = the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_alu_if #(
    parameter int N = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [3:0]    ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  result;
    logic [3:0]    flags;

    modport master (
        output in_valid, a, b, ctrl, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, ctrl, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv
//  Description : Iterative unsigned multiply (shift-add) and divide
//                (restoring), one bit per cycle, N iterations per operation.
//                Ports:
//                  clk, rst          - clock, async active-high reset
//                  i_start           - load operands and begin (one cycle)
//                  i_op              - OP_MUL / OP_DIVU / OP_REMU
//                  i_a, i_b          - operands
//                  o_done            - high during the final iteration cycle;
//                                      o_result/o_carry/o_ovf are valid then
//                  o_result, o_carry, o_ovf
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_start,
    input  wire logic [3:0]    i_op,
    input  wire logic [N-1:0]  i_a,
    input  wire logic [N-1:0]  i_b,
    output logic               o_done,
    output logic [N-1:0]       o_result,
    output logic               o_carry,
    output logic               o_ovf
);
    localparam int            CW     = $clog2(N);
    localparam logic [CW-1:0] c_last = CW'(N - 1);

    // Shared datapath registers:
    //   multiply: r_hi = partial product high half, r_lo = multiplier
    //             (shifting out, product low half shifting in), r_opnd = multiplicand
    //   divide  : r_hi = partial remainder, r_lo = dividend (shifting out,
    //             quotient shifting in), r_opnd = divisor
    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic          r_is_div;
    logic          r_is_rem;
    logic [N-1:0]  r_hi;
    logic [N-1:0]  r_lo;
    logic [N-1:0]  r_opnd;

    logic          w_start_div;
    logic [N:0]    w_sum;
    logic [N-1:0]  w_mul_hi;
    logic [N-1:0]  w_mul_lo;
    logic [N:0]    w_rsh;
    logic          w_ge;
    logic [N-1:0]  w_diff;
    logic [N-1:0]  w_div_hi;
    logic [N-1:0]  w_div_lo;

    assign w_start_div = (i_op == OP_DIVU) || (i_op == OP_REMU);

    // Shift-add step: add multiplicand when multiplier LSB is set, then
    // shift the whole {hi, lo} pair right by one.
    assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(N+1){1'b0}});
    assign w_mul_hi = w_sum[N:1];
    assign w_mul_lo = {w_sum[0], r_lo[N-1:1]};

    // Restoring step: bring in next dividend bit, subtract divisor if it fits.
    // When it fits the difference is below the divisor, so N bits suffice.
    // Divisor 0 always "fits", which naturally yields all-ones / remainder = a.
    assign w_rsh    = {r_hi, r_lo[N-1]};
    assign w_ge     = (w_rsh >= {1'b0, r_opnd});
    assign w_diff   = w_rsh[N-1:0] - r_opnd;
    assign w_div_hi = w_ge ? w_diff : w_rsh[N-1:0];
    assign w_div_lo = {r_lo[N-2:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_is_rem <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_is_div <= w_start_div;
            r_is_rem <= (i_op == OP_REMU);
            r_hi     <= '0;
            r_lo     <= w_start_div ? i_a : i_b;
            r_opnd   <= w_start_div ? i_b : i_a;
        end else if (r_busy) begin
            r_hi  <= r_is_div ? w_div_hi : w_mul_hi;
            r_lo  <= r_is_div ? w_div_lo : w_mul_lo;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Results are taken from the final iteration's next-state values so the
    // caller can finish on the same edge as the last iteration.
    assign o_done   = r_busy && (r_cnt == c_last);
    assign o_result = r_is_rem ? w_div_hi : (r_is_div ? w_div_lo : w_mul_lo);
    assign o_carry  = !r_is_div && (|w_mul_hi);
    assign o_ovf    = r_is_div ? (r_opnd == '0) : (|w_mul_hi);

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Sequential ALU with valid/ready handshakes. Logic, add/sub
//                and shift ops finish one cycle after accept; MUL/DIVU/REMU
//                run N iterations in alu_muldiv. The result is held in DONE
//                until the consumer takes it.
//                Ports:
//                  clk   - clock
//                  rst   - asynchronous active-high reset
//                  bus   - seq_alu_if slave (operation in, result/flags out)
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  wire logic  clk,
    input  wire logic  rst,
    seq_alu_if.slave   bus
);
    localparam int SW = $clog2(N);

    state_t        r_state;
    state_t        w_next_state;
    logic [N-1:0]  r_result;
    logic [3:0]    r_flags;

    logic          w_accept;
    logic          w_is_md;
    logic          w_md_start;
    logic          w_md_done;
    logic [N-1:0]  w_md_result;
    logic          w_md_carry;
    logic          w_md_ovf;

    logic [SW-1:0] w_sh;
    logic [N:0]    w_add;
    logic [N:0]    w_sub;
    logic [N:0]    w_shl;
    logic [N:0]    w_shr;
    logic [N:0]    w_sra;
    logic [N-1:0]  w_res;
    logic          w_carry;
    logic          w_ovf;

    function automatic logic [3:0] pack_flags(input logic [N-1:0] res,
                                              input logic c, input logic v);
        logic [3:0] f;
        f        = 4'b0000;
        f[NEG]   = res[N-1];
        f[ZERO]  = (res == '0);
        f[CARRY] = c;
        f[OVF]   = v;
        return f;
    endfunction

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.flags     = r_flags;

    assign w_accept   = bus.in_valid && (r_state == S_IDLE);
    assign w_is_md    = (bus.ctrl == OP_MUL) || (bus.ctrl == OP_DIVU) ||
                        (bus.ctrl == OP_REMU);
    assign w_md_start = w_accept && w_is_md;

    alu_muldiv #(
        .N (N)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_md_start),
        .i_op     (bus.ctrl),
        .i_a      (bus.a),
        .i_b      (bus.b),
        .o_done   (w_md_done),
        .o_result (w_md_result),
        .o_carry  (w_md_carry),
        .o_ovf    (w_md_ovf)
    );

    // ---------------- single-cycle datapath ----------------
    assign w_sh  = bus.b[SW-1:0];
    assign w_add = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_sub = {1'b0, bus.a} + {1'b0, ~bus.b} + {{N{1'b0}}, 1'b1};
    // Shifts use one extra bit so the last bit shifted out lands in a
    // fixed position; a zero shift leaves that bit at 0.
    assign w_shl = {1'b0, bus.a} << w_sh;
    assign w_shr = {bus.a, 1'b0} >> w_sh;
    assign w_sra = $signed({bus.a, 1'b0}) >>> w_sh;

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (bus.ctrl)
            OP_ADD: begin
                w_res   = w_add[N-1:0];
                w_carry = w_add[N];
                w_ovf   = (bus.a[N-1] == bus.b[N-1]) && (w_add[N-1] != bus.a[N-1]);
            end
            OP_SUB: begin
                w_res   = w_sub[N-1:0];
                w_carry = w_sub[N];
                w_ovf   = (bus.a[N-1] != bus.b[N-1]) && (w_sub[N-1] != bus.a[N-1]);
            end
            OP_AND: w_res = bus.a & bus.b;
            OP_OR:  w_res = bus.a | bus.b;
            OP_XOR: w_res = bus.a ^ bus.b;
            OP_SHL: begin
                w_res   = w_shl[N-1:0];
                w_carry = w_shl[N];
            end
            OP_SHR: begin
                w_res   = w_shr[N:1];
                w_carry = w_shr[0];
            end
            OP_SRA: begin
                w_res   = w_sra[N:1];
                w_carry = w_sra[0];
            end
            default: ; // reserved opcodes: result 0, only zero flag set
        endcase
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next_state = w_is_md ? S_BUSY : S_DONE;
            S_BUSY: if (w_md_done) w_next_state = S_DONE;
            S_DONE: if (bus.out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- result / flags hold registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_flags  <= 4'b0000;
        end else if (w_accept && !w_is_md) begin
            r_result <= w_res;
            r_flags  <= pack_flags(w_res, w_carry, w_ovf);
        end else if ((r_state == S_BUSY) && w_md_done) begin
            r_result <= w_md_result;
            r_flags  <= pack_flags(w_md_result, w_md_carry, w_md_ovf);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu
//  Description : Self-checking bench for seq_alu (N=32). A vector table drives
//                every opcode class; expected results go into a scoreboard
//                queue at issue and are popped when out_valid appears.
//                Hand sequences cover backpressure and reset abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;
    import alu_pkg::*;

    localparam int N = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_alu_if #(.N(N)) bus ();

    seq_alu #(.N(N)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t vt[21];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation, wait for its result, compare against the
    // scoreboard, optionally hold off the consumer for 'hold' cycles.
    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] er, input logic [3:0] ef,
                          input int el, input int hold);
        exp_t e;
        int   cyc;
        @(negedge clk);
        check({name, " in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.a        = x;
        bus.b        = y;
        bus.ctrl     = op;
        sb.push_back('{er, ef, el});
        @(posedge clk);
        @(negedge clk);
        // Operands were captured on the accept edge; scramble them now.
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.ctrl     = 4'($urandom_range(0, 15));
        cyc = 1;
        while (!bus.out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.out_valid) check({name, " timeout"}, 64'(bus.out_valid), 64'd1);
        e = sb.pop_front();
        check({name, " latency"}, 64'(cyc), 64'(e.lat));
        check({name, " result"}, 64'(bus.result), 64'(e.res));
        check({name, " flags"}, 64'(bus.flags), 64'(e.fl));
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.ctrl     = OP_ADD;
            bus.a        = 32'h1111_1111;
            bus.b        = 32'h2222_2222;
            @(negedge clk);
            check({name, " hold result"}, 64'(bus.result), 64'(e.res));
            check({name, " hold flags"}, 64'(bus.flags), 64'(e.fl));
            check({name, " hold in_ready"}, 64'(bus.in_ready), 64'd0);
            check({name, " hold out_valid"}, 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({name, " released"}, 64'(bus.out_valid), 64'd0);
        if (hold > 0) begin
            check({name, " idle after release"}, 64'(bus.in_ready), 64'd1);
            repeat (2) @(negedge clk);
            check({name, " nothing queued"}, 64'(bus.out_valid), 64'd0);
        end
    endtask

    initial begin
        logic seen;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.ctrl      = '0;

        vt[0]  = '{OP_ADD,  32'd10,        32'd256,       32'd266,       4'b0000, 1};
        vt[1]  = '{OP_SUB,  32'd10,        32'd10,        32'd0,         4'b0110, 1};
        vt[2]  = '{OP_SUB,  32'd1,         32'd10,        32'hFFFF_FFF7, 4'b1000, 1};
        vt[3]  = '{OP_ADD,  32'd24,        32'hFFFF_FFF6, 32'd14,        4'b0010, 1};
        vt[4]  = '{OP_ADD,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 4'b1001, 1};
        vt[5]  = '{OP_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 4'b0000, 1};
        vt[6]  = '{OP_OR,   32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 4'b1000, 1};
        vt[7]  = '{OP_XOR,  32'h1234_5678, 32'h1234_5678, 32'd0,         4'b0100, 1};
        vt[8]  = '{OP_SHR,  32'd3,         32'd1,         32'd1,         4'b0010, 1};
        vt[9]  = '{OP_SRA,  32'h8000_0018, 32'd4,         32'hF800_0001, 4'b1010, 1};
        vt[10] = '{OP_SHL,  32'hC000_0000, 32'h0000_0021, 32'h8000_0000, 4'b1010, 1};
        vt[11] = '{OP_SHL,  32'd5,         32'h0000_0020, 32'd5,         4'b0000, 1};
        vt[12] = '{4'b1100, 32'd5,         32'd5,         32'd0,         4'b0100, 1};
        vt[13] = '{OP_MUL,  32'h0001_0000, 32'h0001_0000, 32'd0,         4'b0111, 33};
        vt[14] = '{OP_MUL,  32'd123,       32'd45,        32'd5535,      4'b0000, 33};
        vt[15] = '{OP_DIVU, 32'd100,       32'd7,         32'd14,        4'b0000, 33};
        vt[16] = '{OP_REMU, 32'd100,       32'd7,         32'd2,         4'b0000, 33};
        vt[17] = '{OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 4'b1001, 33};
        vt[18] = '{OP_REMU, 32'd5,         32'd0,         32'd5,         4'b0001, 33};
        vt[19] = '{OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         4'b0011, 33};
        vt[20] = '{OP_REMU, 32'hFFFF_FFFF, 32'd1,         32'd0,         4'b0100, 33};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset result", 64'(bus.result), 64'd0);
        check("reset flags", 64'(bus.flags), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", 64'(bus.in_ready), 64'd1);

        for (int i = 0; i < 21; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b,
                   vt[i].res, vt[i].fl, vt[i].lat, 0);
        end

        // Backpressure: consumer stalls 5 cycles while in_valid pulses
        run_op("backpressure", OP_ADD, 32'd1, 32'd2, 32'd3, 4'b0000, 1, 5);

        // Reset abort in the middle of a multiply
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.ctrl     = OP_MUL;
        bus.a        = 32'd7;
        bus.b        = 32'd9;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("abort busy in_ready", 64'(bus.in_ready), 64'd0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort out_valid", 64'(bus.out_valid), 64'd0);
        check("abort result", 64'(bus.result), 64'd0);
        check("abort flags", 64'(bus.flags), 64'd0);
        check("abort in_ready", 64'(bus.in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("abort no result", 64'(seen), 64'd0);

        run_op("shl after abort", OP_SHL, 32'd1, 32'd31, 32'h8000_0000, 4'b1000, 1, 0);

        check("scoreboard empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter N, default 32, datapath width in bits (legal range 8..64).
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid  input  1  operand/opcode presented.
REQ-005 The block SHALL have port in_ready  output  1  block can accept an operation.
REQ-006 The block SHALL have port a  input  N  first operand.
REQ-007 The block SHALL have port b  input  N  second operand; shift amount is b[$clog2(N)-1:0].
REQ-008 The block SHALL have port ctrl  input  4  opcode.
REQ-009 The block SHALL have port out_valid  output  1  result and flags valid.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 The block SHALL have port result  output  N  operation result.
REQ-012 The block SHALL have port flags  output  4  {neg, zero, carry, overflow}.

Function
REQ-013 Opcodes SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SHL, 0110 SHR (logical), 0111 SRA, 1000 MUL (low N bits, unsigned), 1001 DIVU, 1010 REMU.
REQ-014 Opcodes 1011..1111 SHALL complete as single-cycle ops with result 0 and flags 0100.
REQ-015 FSM states SHALL be IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-016 Accept SHALL occur on the edge where in_valid && in_ready; a, b, ctrl are captured then and may change afterwards.
REQ-017 Single-cycle ops: IDLE -> DONE on accept; out_valid asserted the cycle after accept.
REQ-018 MUL/DIVU/REMU: IDLE -> BUSY on accept; exactly N iteration cycles; BUSY -> DONE; out_valid asserted N+1 cycles after accept.
REQ-019 DONE SHALL hold result and flags stable until out_valid && out_ready, then go to IDLE on that edge.
REQ-020 in_valid during BUSY or DONE SHALL be ignored; no operation is queued.
REQ-021 neg = result[N-1]; zero = (result == 0) for every opcode.
REQ-022 ADD: carry = unsigned carry-out, overflow = signed overflow.
REQ-023 SUB: computed as a + ~b + 1; carry = 1 when no borrow (a >= b unsigned), overflow = signed overflow.
REQ-024 AND/OR/XOR: carry = 0, overflow = 0.
REQ-025 Shifts: carry = last bit shifted out, 0 when shift amount is 0; overflow = 0.
REQ-026 MUL: multiplication SHALL be shift-add, one bit per cycle; carry = overflow = 1 when the upper N bits of the 2N-bit product are nonzero.
REQ-027 DIVU/REMU: division SHALL be restoring, one quotient bit per cycle; carry = 0, overflow = 0.
REQ-028 Divide by zero: DIVU result all-ones, REMU result = a, overflow = 1, carry = 0, with identical N-cycle latency.

Reset
REQ-029 While rst is high, state SHALL be IDLE, out_valid = 0, result = 0, flags = 0000, and all iteration registers are cleared; in_ready SHALL be 1 from the first clk edge after rst deasserts.
REQ-030 rst asserted during BUSY or DONE SHALL abort the operation; no out_valid is produced for it.

Structure
REQ-031 Package alu_pkg SHALL hold the opcode enum, the FSM state enum and flag bit-index constants (NEG=3, ZERO=2, CARRY=1, OVF=0).
REQ-032 The iterative multiply/divide datapath SHALL be one sub-module, alu_muldiv, with start/done signalling.
REQ-033 The single-cycle ops and flag generation SHALL stay in seq_alu.

Verification (N=32)
REQ-034 ADD a=10, b=256 -> result 266, flags 0000, out_valid exactly 1 cycle after accept.
REQ-035 SUB 10-10 -> result 0, flags 0110; SUB 1-10 -> result 0xFFFFFFF7, flags 1000; ADD 24 + (-10) -> 14, flags 0010; ADD 0x7FFFFFFF+1 -> 0x80000000, flags 1001.
REQ-036 MUL 0x00010000*0x00010000 -> result 0, flags 0111, out_valid exactly 33 cycles after accept; MUL 123*45 -> 5535, flags 0000.
REQ-037 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF, flags 1001; REMU 5/0 -> 5, flags 0001.
REQ-038 Backpressure: out_ready low for 5 cycles after out_valid -> result/flags stable, in_ready 0, in_valid pulses ignored; IDLE on the first out_ready edge.
REQ-039 rst pulse at cycle 10 of a MUL -> out_valid 0, no result emitted; after release, SHL 1<<31 -> 0x80000000, flags 1000.
